// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: data width, RX FIFO defaults and the tagged entry
// layout. The tagged layout is used when UART_RX_FIFO_ERR_TAG_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_RX_FIFO_DEPTH     = 16;
    localparam int UART_RX_FIFO_AF_THRESH = 12;

    // One received character plus the line-error flags seen while receiving it.
    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   frame_err;
        logic                   parity_err;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-facing write port and host-facing FWFT read port of the RX FIFO.
// The error-tag signals exist only when UART_RX_FIFO_ERR_TAG_EN is defined.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic              wr_frame_err;
    logic              wr_parity_err;
    logic              rd_frame_err;
    logic              rd_parity_err;
`endif

    // Side that produces bytes and consumes them (receiver + host).
    modport master (
        output wr_en, wr_data, rd_ready,
`ifdef UART_RX_FIFO_ERR_TAG_EN
        output wr_frame_err, wr_parity_err,
        input  rd_frame_err, rd_parity_err,
`endif
        input  full, rd_valid, rd_data
    );

    // The FIFO itself.
    modport slave (
        input  wr_en, wr_data, rd_ready,
`ifdef UART_RX_FIFO_ERR_TAG_EN
        input  wr_frame_err, wr_parity_err,
        output rd_frame_err, rd_parity_err,
`endif
        output full, rd_valid, rd_data
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are intentionally not reset; validity is tracked by the owner.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one entry per write strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read so the FIFO head is visible in the same cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through read side, occupancy count,
// almost-full and a sticky overflow flag. Writes into a full FIFO are dropped.
// Optional feature macro: UART_RX_FIFO_ERR_TAG_EN stores frame/parity error
// tags alongside each byte.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,   // power of 2, >= 2
    parameter int AF_THRESH = UART_RX_FIFO_AF_THRESH // 1..DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_rx_fifo_if.slave            bus,
    input  logic                     flush,
    input  logic                     clr_overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic empty;
    logic full_w;
    logic push;
    logic pop;
    logic drop;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int ENTRY_W = $bits(rx_entry_t);
    rx_entry_t wr_entry;
    rx_entry_t rd_entry;
    assign wr_entry = '{data:       bus.wr_data,
                        frame_err:  bus.wr_frame_err,
                        parity_err: bus.wr_parity_err};
    assign bus.rd_data       = rd_entry.data;
    assign bus.rd_frame_err  = rd_entry.frame_err;
    assign bus.rd_parity_err = rd_entry.parity_err;
`else
    localparam int ENTRY_W = DATA_W;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    assign wr_entry    = bus.wr_data;
    assign bus.rd_data = rd_entry;
`endif

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_w = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Full is judged before any same-cycle pop, so dropping a write never
    // depends on what the consumer does.
    assign push = bus.wr_en & ~full_w;
    assign drop = bus.wr_en &  full_w;
    assign pop  = ~empty & bus.rd_ready;

    assign bus.full     = full_w;
    assign bus.rd_valid = ~empty;
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign overflow     = overflow_q;

    uart_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~flush),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

    // Next pointers and overflow flag; flush wins over push/pop but leaves
    // overflow alone, and a drop wins over clr_overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // State register with synchronous reset; memory is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
